// File: rtl/debounce_pkg.sv
// Shared types and helpers for the shared-timer button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK
    } dbs_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Round-robin pick of the first requester after the last grant.
module rr_arbiter
    import debounce_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] k;

    // Scan from last+1 so the previous winner is tried last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last) + i) % N);
            if (!gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = k;
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// N-button debouncer sharing one stable-time timer via round-robin grants.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_BUTTONS-1:0]                  button_in,
    output logic [N_BUTTONS-1:0]                  stable,
    output logic [N_BUTTONS-1:0]                  press_pulse,
    output logic [N_BUTTONS-1:0]                  release_pulse,
    output logic                                  busy,
    output logic [clog2_min1(N_BUTTONS)-1:0]      grant_idx
);

    localparam int IW = clog2_min1(N_BUTTONS);
    localparam int TW = clog2_min1(DEBOUNCE_CYCLES + 1);
    localparam logic [N_BUTTONS-1:0] IDLE_LVL = {N_BUTTONS{ACTIVE_LOW}};
    localparam logic PRESSED = ~ACTIVE_LOW;
    localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

    dbs_state_t state, state_nxt;

    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync_q;
    logic [N_BUTTONS-1:0] stable_q;
    logic [N_BUTTONS-1:0] press_q;
    logic [N_BUTTONS-1:0] release_q;
    logic [N_BUTTONS-1:0] pending;
    logic [TW-1:0]        timer_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        last_q;
    logic                 sample_q;
    logic                 arb_valid;
    logic [IW-1:0]        arb_idx;
    logic                 accept;

    assign pending = sync_q ^ stable_q;
    assign accept  = (state == CHECK)
                   && (sync_q[grant_q] == sample_q)
                   && (sample_q != stable_q[grant_q]);

    rr_arbiter #(
        .N  (N_BUTTONS),
        .IW (IW)
    ) u_arb (
        .req       (pending),
        .last      (last_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (arb_valid) state_nxt = WAIT;
            WAIT:    if (timer_q == T_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == WAIT) || (state == CHECK);
        stable        = stable_q;
        press_pulse   = press_q;
        release_pulse = release_q;
        grant_idx     = grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE_LVL;
            sync_q  <= IDLE_LVL;
        end else begin
            sync1_q <= button_in;
            sync_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q  <= IDLE_LVL;
            press_q   <= '0;
            release_q <= '0;
            timer_q   <= '0;
            grant_q   <= '0;
            last_q    <= IW'(N_BUTTONS - 1);
            sample_q  <= ACTIVE_LOW;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q  <= arb_idx;
                        sample_q <= sync_q[arb_idx];
                        timer_q  <= '0;
                    end
                end
                WAIT: timer_q <= timer_q + TW'(1);
                CHECK: begin
                    last_q <= grant_q;
                    if (accept) begin
                        stable_q[grant_q] <= sample_q;
                        if (sample_q == PRESSED) press_q[grant_q] <= 1'b1;
                        else release_q[grant_q] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler (4 buttons, 8-cycle window).
module tb_debounce_scheduler;

    localparam int NB  = 4;
    localparam int DC  = 8;
    localparam int LAT = DC + 4;

    typedef struct {
        int       cyc;
        logic [3:0] prs;
        logic [3:0] rls;
        logic [3:0] stb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button_in;
    logic [3:0] stable;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       busy;
    logic [1:0] grant_idx;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    debounce_scheduler #(
        .N_BUTTONS       (NB),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button_in     (button_in),
        .stable        (stable),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (press_pulse | release_pulse) != 4'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cycle=%0d press=%b release=%b, required none",
                             cyc, press_pulse, release_pulse);
                end else begin
                    e = q.pop_front();
                    if (cyc !== e.cyc || press_pulse !== e.prs ||
                        release_pulse !== e.rls || stable !== e.stb) begin
                        errors++;
                        $display("FAIL pulse: cycle=%0d press=%b release=%b stable=%b, required cycle=%0d press=%b release=%b stable=%b",
                                 cyc, press_pulse, release_pulse, stable,
                                 e.cyc, e.prs, e.rls, e.stb);
                    end
                end
            end
        end
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] p,
                                input logic [3:0] r, input logic [3:0] s);
        exp_t e;
        e.cyc = c;
        e.prs = p;
        e.rls = r;
        e.stb = s;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: outstanding=%0d, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_idle(input string name, input logic [3:0] stb);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stable !== stb) begin
            errors++;
            $display("FAIL %s_idle: busy=%b stable=%b, required busy=0 stable=%b",
                     name, busy, stable, stb);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        button_in = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_grant: grant_idx=%0d, required 0", grant_idx);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (stable !== 4'hF || press_pulse !== 4'h0 ||
                release_pulse !== 4'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: stable=%b press=%b release=%b busy=%b, required 1111 0000 0000 0",
                         stable, press_pulse, release_pulse, busy);
            end
        end
    endtask

    task automatic test_press_release();
        @(negedge clk);
        button_in[2] = 1'b0;
        expect_pulse(cyc + LAT, 4'b0100, 4'b0000, 4'b1011);
        wait_drain("press");
        check_idle("press", 4'b1011);
        @(negedge clk);
        button_in[2] = 1'b1;
        expect_pulse(cyc + LAT, 4'b0000, 4'b0100, 4'b1111);
        wait_drain("release");
        check_idle("release", 4'b1111);
    endtask

    task automatic test_bounce();
        @(negedge clk);
        button_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        button_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL bounce_grant: busy=%b grant_idx=%0d, required 1 1", busy, grant_idx);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stable !== 4'hF || dut.pending !== 4'h0) begin
            errors++;
            $display("FAIL bounce_reject: busy=%b stable=%b pending=%b, required 0 1111 0000",
                     busy, stable, dut.pending);
        end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        button_in = 4'b0110;
        expect_pulse(cyc + LAT, 4'b0001, 4'b0000, 4'b1110);
        expect_pulse(cyc + LAT + DC + 2, 4'b1000, 4'b0000, 4'b0110);
        wait_drain("contention_press");
        check_idle("contention_press", 4'b0110);
        @(negedge clk);
        button_in = 4'b1111;
        expect_pulse(cyc + LAT, 4'b0000, 4'b0001, 4'b0111);
        expect_pulse(cyc + LAT + DC + 2, 4'b0000, 4'b1000, 4'b1111);
        wait_drain("contention_release");
        check_idle("contention_release", 4'b1111);
    endtask

    task automatic test_fairness();
        logic       prev_busy = 1'b0;
        logic [1:0] exp_idx = 2'd0;
        int         got = 0;
        int         n = 0;
        do_reset();
        while (got < 8 && n < 300) begin
            @(negedge clk);
            button_in = ~button_in;
            n++;
            if (busy && !prev_busy) begin
                checks++;
                if (grant_idx !== exp_idx) begin
                    errors++;
                    $display("FAIL fairness_order: grant_idx=%0d, required %0d", grant_idx, exp_idx);
                end
                exp_idx = exp_idx + 2'd1;
                got++;
            end
            prev_busy = busy;
        end
        checks++;
        if (got < 8) begin
            errors++;
            $display("FAIL fairness_timeout: grants=%0d, required 8", got);
        end
        button_in = 4'hF;
        repeat (30) @(negedge clk);
        check_idle("fairness", 4'hF);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        button_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midwait_busy: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        button_in = 4'hF;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stable !== 4'hF || press_pulse !== 4'h0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL midwait_reset: busy=%b stable=%b press=%b grant=%0d, required 0 1111 0000 0",
                     busy, stable, press_pulse, grant_idx);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_idle("midwait", 4'hF);
    endtask

    initial begin
        rst = 1'b1;
        button_in = 4'hF;
        fork
            monitor();
        join_none
        test_reset();
        test_press_release();
        test_bounce();
        test_contention();
        test_fairness();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N mechanical push-buttons using one shared debounce timer instead of one counter per button.
- A round-robin scheduler grants the timer to each button whose synchronized level differs from its debounced state.
- The block emits debounced levels plus one-cycle press/release pulses.
- It sits between the board buttons and the LED/segment counter logic, replacing per-button debounce state machines.

Parameters:
N_BUTTONS, 4, number of button inputs (2..16)
DEBOUNCE_CYCLES, 1000000, stable-time window in clk cycles (20 ms at 50 MHz); minimum 2
ACTIVE_LOW, 1, 1 = a pressed button drives 0 and the idle level is 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
button_in  input  N_BUTTONS  raw asynchronous button pins
stable  output  N_BUTTONS  debounced button levels (raw polarity)
press_pulse  output  N_BUTTONS  one-cycle pulse when a debounced press is accepted
release_pulse  output  N_BUTTONS  one-cycle pulse when a debounced release is accepted
busy  output  1  high while the shared timer is granted (states WAIT and CHECK)
grant_idx  output  $clog2(N_BUTTONS)  index currently or most recently granted

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values:
  - stable and both synchronizer stages = {N{ACTIVE_LOW}} (the idle level).
  - press_pulse = 0, release_pulse = 0, busy = 0.
  - grant_idx = 0; last_grant = N_BUTTONS-1, so button 0 wins the first arbitration.
  - state = IDLE, timer = 0.
- Synchronizer: two flops per bit, sync = second stage.
- Pending: pending[i] = sync[i] != stable[i]. It is combinational and there is no sticky flag, so a bounced button re-requests automatically.
- FSM states IDLE, WAIT, CHECK:
  - IDLE: if any pending bit is set, rr_arbiter picks the first pending index after last_grant (wrapping). On that edge: grant_idx <= pick, sample <= sync[pick], timer <= 0, go to WAIT. If nothing is pending, stay in IDLE.
  - WAIT: timer increments every cycle. When timer == DEBOUNCE_CYCLES-1, go to CHECK.
  - CHECK: if sync[grant_idx] == sample and sample != stable[grant_idx], then stable[grant_idx] <= sample and the matching pulse bit <= 1. Otherwise no update (bounce rejected). In both cases last_grant <= grant_idx and the FSM returns to IDLE.
- Pulse polarity: a press is stable going to the pressed level (0 when ACTIVE_LOW=1); a release is the opposite.
- Pulse timing: pulses are registered, high for exactly one cycle, and at most one bit of press_pulse|release_pulse is set in any cycle.
- Latency, uncontended: new level sampled by sync stage 1 at edge 0 → pulse and stable update visible after edge DEBOUNCE_CYCLES+3.
- Timer width: $clog2(DEBOUNCE_CYCLES+1). The timer never wraps because it is cleared on every grant.
- Contention:
  - Other buttons that become pending during WAIT/CHECK wait for a later grant.
  - Worst-case wait for any button is (N_BUTTONS-1)·(DEBOUNCE_CYCLES+2) cycles before its own grant.
  - The button just serviced has the lowest priority at the next arbitration.
- Input changes during WAIT: the granted input may toggle freely; only its level at CHECK is compared with sample.
- Reset during WAIT/CHECK: abort immediately, no pulse, all values return to reset values.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, CHECK} dbs_state_t
  - function clog2_min1 (returns at least 1, so N_BUTTONS=1 tooling does not break)
- Sub-module rr_arbiter #(N): purely combinational.
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: gnt_valid, gnt_idx.
  - Rotate-priority search starting at last+1.
  - Unit-testable on its own.

Test Plan (N_BUTTONS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1):
- Reset, all inputs 1 → stable=4'b1111, no pulses, busy=0 for 50 cycles.
- Clean press, button_in[2] 1→0 held → press_pulse=4'b0100 for exactly one cycle, 11 edges after the first sampling edge; stable=4'b1011. Later release to 1 → release_pulse=4'b0100 and stable=4'b1111.
- Bounce, button_in[1] 1→0 then back to 1 after 3 cycles → CHECK rejects, no pulse, stable unchanged, FSM returns to IDLE with pending clear.
- Contention, buttons 0 and 3 pressed in the same cycle → button 0 pulses first. Button 3 pulses 10 cycles later, since round-robin starts after last_grant=3, so 0 wins.
- Fairness: hold buttons 0..3 chattering continuously → grant_idx sequence 0,1,2,3,0,… with no index repeated until all others are served.
- Reset mid-WAIT → after the rst edge: busy=0, no pulse ever emitted for the aborted grant, stable=4'b1111.
